// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use hazards,
// taken branches and multi-cycle memory waits into per-cycle freeze/clear controls.
module pipeline_ctrl #(
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic        mem_req,
    output logic        freeze_front,
    output logic        flush_ifid,
    output logic        bubble_idex,
    output logic        freeze_back,
    output logic        busy,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DONE     = 2'b10
    } state_t;

    localparam bit MEM_WAIT_EN = (MEM_WAIT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
        MEM_WAIT_EN ? CNT_WIDTH'(MEM_WAIT_CYCLES - 1) : '0;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    // Outputs are gated by rst so they drop the moment reset asserts,
    // even while hazard/branch_taken are still high.
    always_comb begin
        freeze_front = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        freeze_back  = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            unique case (state)
                MEM_WAIT: begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    busy         = 1'b1;
                end
                default: begin
                    if (branch_taken) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (hazard) begin
                        freeze_front = 1'b1;
                        bubble_idex  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req && MEM_WAIT_EN) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (freeze_front && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_WAIT_CYCLES=4.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic        branch_taken;
    logic        mem_req;
    logic        freeze_front;
    logic        flush_ifid;
    logic        bubble_idex;
    logic        freeze_back;
    logic        busy;
    logic [15:0] stall_cycles;
    logic [4:0]  ctrl;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.MEM_WAIT_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .freeze_front (freeze_front),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .freeze_back  (freeze_back),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    // {freeze_front, flush_ifid, bubble_idex, freeze_back, busy}
    assign ctrl = {freeze_front, flush_ifid, bubble_idex, freeze_back, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        hazard = 1'b1;
        branch_taken = 1'b1;
        mem_req = 1'b1;

        // Reset held with all inputs active
        repeat (3) tick();
        mid();
        check("rst_ctrl", 32'(ctrl), 32'h00);
        check("rst_stall", 32'(stall_cycles), 32'd0);

        tick();
        hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
        rst = 1'b1;
        mid();
        check("idle_ctrl", 32'(ctrl), 32'h00);

        // Load-use for one cycle
        tick();
        hazard = 1'b1;
        mid();
        check("ldu_ctrl", 32'(ctrl), 32'b10100);
        tick();
        hazard = 1'b0;
        check("ldu_stall", 32'(stall_cycles), 32'd1);
        mid();
        check("ldu_after", 32'(ctrl), 32'h00);

        // Branch beats hazard
        tick();
        hazard = 1'b1; branch_taken = 1'b1;
        mid();
        check("br_prio", 32'(ctrl), 32'b01100);
        tick();
        hazard = 1'b0; branch_taken = 1'b0;
        check("br_stall", 32'(stall_cycles), 32'd1);

        // Memory wait: mem_req held, cycle t in RUN
        mem_req = 1'b1;
        mid();
        check("mem_t", 32'(ctrl), 32'h00);
        for (int k = 1; k <= 4; k++) begin
            tick();
            branch_taken = (k == 2);
            hazard = (k == 3);
            mid();
            check($sformatf("mem_wait%0d", k), 32'(ctrl), 32'b10011);
        end
        // DONE: mem_req ignored, hazard acts as in RUN
        tick();
        branch_taken = 1'b0;
        hazard = 1'b1;
        mid();
        check("done_ctrl", 32'(ctrl), 32'b10100);
        tick();
        hazard = 1'b0;
        check("done_stall", 32'(stall_cycles), 32'd6);
        mid();
        check("rerun_ctrl", 32'(ctrl), 32'h00);
        tick();
        mid();
        check("wait2_ctrl", 32'(ctrl), 32'b10011);

        // Reset mid-wait
        tick();
        rst = 1'b0;
        #1;
        check("mrst_ctrl", 32'(ctrl), 32'h00);
        check("mrst_stall", 32'(stall_cycles), 32'd0);
        tick();
        mem_req = 1'b0;
        rst = 1'b1;
        mid();
        check("mrst_run", 32'(ctrl), 32'h00);
        tick();
        check("mrst_stall2", 32'(stall_cycles), 32'd0);

        // Branch plus mem_req in RUN
        branch_taken = 1'b1; mem_req = 1'b1;
        mid();
        check("brmem_t", 32'(ctrl), 32'b01100);
        tick();
        branch_taken = 1'b0; mem_req = 1'b0;
        mid();
        check("brmem_t1", 32'(ctrl), 32'b10011);
        repeat (4) tick();
        mid();
        check("brmem_done", 32'(ctrl), 32'h00);
        tick();
        check("brmem_stall", 32'(stall_cycles), 32'd4);

        // Saturation
        hazard = 1'b1;
        repeat (70000) tick();
        check("sat", 32'(stall_cycles), 32'hFFFF);
        tick();
        check("sat_hold", 32'(stall_cycles), 32'hFFFF);
        hazard = 1'b0;
        mid();
        check("final_ctrl", 32'(ctrl), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
